// File: rtl/rh_cs1_ctl.sv
`default_nettype none
// ============================================================================
// Module   : rh_cs1_ctl
// Purpose  : RH11 CS1 controller: command GO pulses, Ready/Busy transfer FSM,
//            TRE error edge detection, interrupt request and CS1 readback.
// Revision : 1.0  initial release
// ============================================================================
module rh_cs1_ctl #(
  parameter int NDRV = 8,
  parameter int NERR = 8,
  localparam int SELW = (NDRV > 1) ? $clog2(NDRV) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 devRESET,
  input  logic                 devLOBYTE,
  input  logic                 devHIBYTE,
  input  logic [0:35]          devDATAI,
  input  logic                 rhcs1WRITE,
  input  logic                 rhCLR,
  input  logic [NERR-1:0]      errSTAT,
  input  logic [NDRV-1:0]      drvATA,
  input  logic [SELW-1:0]      drvSEL,
  input  logic [16*NDRV-1:0]   drvCS1,
  input  logic [1:0]           rhBA,
  input  logic                 xferDONE,
  input  logic                 intrDONE,
  output logic                 goCMD,
  output logic [4:0]           funOUT,
  output logic                 xferBUSY,
  output logic                 intrREQ,
  output logic [15:0]          rhCS1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_enter_done;

  logic            r_tre;
  logic            r_psel;
  logic            r_ie;
  logic            r_irq;
  logic            r_go;
  logic [4:0]      r_fun;
  logic [NERR-1:0] r_lasterr;
  logic            r_lastata;

  logic [35:0]     w_d;
  logic [15:0]     w_img;
  logic            w_clr;
  logic            w_lowr;
  logic            w_hiwr;
  logic            w_rdy;
  logic            w_cmd;
  logic            w_xfer;
  logic            w_issue;
  logic            w_err_rise;
  logic            w_ata;
  logic            w_sc;

  // Big-endian bus: a plain vector copy puts devDATAI[35-k] at w_d[k].
  assign w_d        = devDATAI;
  assign w_clr      = rst | devRESET | rhCLR;
  assign w_lowr     = rhcs1WRITE & devLOBYTE;
  assign w_hiwr     = rhcs1WRITE & devHIBYTE;
  assign w_rdy      = (r_state != S_BUSY);
  assign w_cmd      = w_lowr & w_d[0];
  assign w_xfer     = w_d[5] & (w_d[4] | w_d[3]);
  assign w_issue    = w_cmd & (~w_xfer | w_rdy);
  assign w_err_rise = |(errSTAT & ~r_lasterr);
  assign w_ata      = |drvATA;
  assign w_sc       = r_tre | w_ata;

  always_comb begin
    w_img = 16'h0000;
    for (int i = 0; i < NDRV; i++) begin
      if (drvSEL == SELW'(i)) w_img = drvCS1[16*i +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = (w_issue & w_xfer) ? S_BUSY : S_IDLE;
      S_BUSY: begin
        if (xferDONE | r_tre) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_tre     <= 1'b0;
      r_psel    <= 1'b0;
      r_ie      <= 1'b0;
      r_irq     <= 1'b0;
      r_go      <= 1'b0;
      r_fun     <= 5'd0;
      r_lasterr <= '0;
      r_lastata <= 1'b0;
    end else begin
      r_lasterr <= errSTAT;
      r_lastata <= w_ata;
      r_go      <= w_issue;
      if (w_issue) r_fun <= w_d[5:1];
      // Clearing TRE takes priority over a simultaneous new error edge.
      if ((w_hiwr & w_d[14]) | w_issue) r_tre <= 1'b0;
      else if (w_err_rise)              r_tre <= 1'b1;
      if (w_hiwr & w_rdy) r_psel <= w_d[10];
      if (intrDONE)    r_ie <= 1'b0;
      else if (w_lowr) r_ie <= w_d[6];
      if (intrDONE) r_irq <= 1'b0;
      else if (r_ie & (w_enter_done | (w_ata & ~r_lastata))) r_irq <= 1'b1;
    end
  end

  assign goCMD    = r_go;
  assign funOUT   = r_fun;
  assign xferBUSY = (r_state == S_BUSY);
  assign intrREQ  = r_irq;
  assign rhCS1    = {w_sc, r_tre, 1'b0, 1'b1, w_img[11], r_psel, rhBA,
                     w_rdy, r_ie, w_img[5:1], w_img[0]};

  logic w_unused;
  assign w_unused = &{1'b0, w_d[35:15], w_d[13:11], w_d[9:7], w_img[15:12], w_img[10:6]};

endmodule
`default_nettype wire

// File: tb/tb_rh_cs1_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rh_cs1_ctl
// Purpose  : Directed plus randomized bench for rh_cs1_ctl (NDRV=2, NERR=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rh_cs1_ctl;
  localparam int ND = 2;
  localparam int NE = 4;

  logic              clk = 1'b0;
  logic              rst, devRESET, devLOBYTE, devHIBYTE, rhcs1WRITE, rhCLR;
  logic [0:35]       devDATAI;
  logic [NE-1:0]     errSTAT;
  logic [ND-1:0]     drvATA;
  logic [0:0]        drvSEL;
  logic [16*ND-1:0]  drvCS1;
  logic [1:0]        rhBA;
  logic              xferDONE, intrDONE;
  logic              goCMD, xferBUSY, intrREQ;
  logic [4:0]        funOUT;
  logic [15:0]       rhCS1;

  int npass  = 0;
  int ntotal = 0;

  // Reference model state; phase 0 = idle, 1 = transfer running, 2 = just finished.
  int            m_phase;
  logic          m_tre, m_psel, m_ie, m_irq, m_go, m_lastata;
  logic [4:0]    m_fun;
  logic [NE-1:0] m_lasterr;

  rh_cs1_ctl #(.NDRV(ND), .NERR(NE)) dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .devLOBYTE(devLOBYTE),
    .devHIBYTE(devHIBYTE), .devDATAI(devDATAI), .rhcs1WRITE(rhcs1WRITE),
    .rhCLR(rhCLR), .errSTAT(errSTAT), .drvATA(drvATA), .drvSEL(drvSEL),
    .drvCS1(drvCS1), .rhBA(rhBA), .xferDONE(xferDONE), .intrDONE(intrDONE),
    .goCMD(goCMD), .funOUT(funOUT), .xferBUSY(xferBUSY), .intrREQ(intrREQ),
    .rhCS1(rhCS1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_cs1();
    logic [15:0] img;
    int          idx;
    idx = int'(drvSEL);
    img = drvCS1[16*idx +: 16];
    return {m_tre | (drvATA != 0), m_tre, 1'b0, 1'b1, img[11], m_psel, rhBA,
            m_phase != 1, m_ie, img[5:1], img[0]};
  endfunction

  task automatic model_step();
    logic [15:0] d;
    logic        lo, hi, rdy, cmd, xfer, issue, fin, att_edge;
    int          nphase;
    for (int k = 0; k < 16; k++) d[k] = devDATAI[35-k];
    if (rst || devRESET || rhCLR) begin
      m_phase = 0; m_tre = 0; m_psel = 0; m_ie = 0; m_irq = 0; m_go = 0;
      m_fun = 0; m_lasterr = 0; m_lastata = 0;
      return;
    end
    lo    = rhcs1WRITE && devLOBYTE;
    hi    = rhcs1WRITE && devHIBYTE;
    rdy   = (m_phase != 1);
    cmd   = lo && d[0];
    xfer  = (d[5:1] >= 5'o24);
    issue = cmd && (!xfer || rdy);
    fin   = (m_phase == 1) && (xferDONE || m_tre);
    if (m_phase == 1) nphase = fin ? 2 : 1;
    else              nphase = (issue && xfer) ? 1 : 0;
    att_edge = (drvATA != 0) && !m_lastata;
    if (intrDONE) m_irq = 0;
    else if (m_ie && (fin || att_edge)) m_irq = 1;
    if ((hi && d[14]) || issue) m_tre = 0;
    else if ((errSTAT & ~m_lasterr) != 0) m_tre = 1;
    if (hi && rdy) m_psel = d[10];
    if (intrDONE) m_ie = 0;
    else if (lo)  m_ie = d[6];
    m_go = issue;
    if (issue) m_fun = d[5:1];
    m_lasterr = errSTAT;
    m_lastata = (drvATA != 0);
    m_phase   = nphase;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("goCMD",    {15'd0, goCMD},    {15'd0, m_go});
    chk("funOUT",   {11'd0, funOUT},   {11'd0, m_fun});
    chk("xferBUSY", {15'd0, xferBUSY}, {15'd0, m_phase == 1});
    chk("intrREQ",  {15'd0, intrREQ},  {15'd0, m_irq});
    chk("rhCS1",    rhCS1,             model_cs1());
  endtask

  task automatic wr_lo(input logic [15:0] v);
    devDATAI = {20'd0, v}; devLOBYTE = 1; devHIBYTE = 0; rhcs1WRITE = 1;
    tick();
    rhcs1WRITE = 0; devLOBYTE = 0;
  endtask

  task automatic wr_hi(input logic [15:0] v);
    devDATAI = {20'd0, v}; devLOBYTE = 0; devHIBYTE = 1; rhcs1WRITE = 1;
    tick();
    rhcs1WRITE = 0; devHIBYTE = 0;
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1; devRESET = 0; devLOBYTE = 0; devHIBYTE = 0; rhcs1WRITE = 0; rhCLR = 0;
    devDATAI = '0; errSTAT = '0; drvATA = '0; drvSEL = '0; rhBA = 2'b10;
    drvCS1 = 32'h0A35_0817; xferDONE = 0; intrDONE = 0;
    tick(); tick();
    chk("rst_rdy", {15'd0, rhCS1[7]}, 16'd1);
    chk("rst_tre", {15'd0, rhCS1[14]}, 16'd0);
    chk("rst_irq", {15'd0, intrREQ}, 16'd0);
    chk("rst_go",  {15'd0, goCMD}, 16'd0);
    rst = 0;
    tick();

    wr_lo(16'o161);
    chk("go_pulse", {15'd0, goCMD}, 16'd1);
    chk("go_fun",   {11'd0, funOUT}, 16'o30);
    chk("go_rdy",   {15'd0, rhCS1[7]}, 16'd0);
    tick();
    chk("go_width", {15'd0, goCMD}, 16'd0);
    wr_lo(16'o7);
    chk("nx_go",   {15'd0, goCMD}, 16'd1);
    chk("nx_fun",  {11'd0, funOUT}, 16'd3);
    chk("nx_busy", {15'd0, xferBUSY}, 16'd1);
    wr_lo(16'o61);
    chk("busy_ign", {15'd0, goCMD}, 16'd0);
    wr_lo(16'o161);
    xferDONE = 1; tick(); xferDONE = 0;
    chk("done_rdy", {15'd0, rhCS1[7]}, 16'd1);
    chk("done_irq", {15'd0, intrREQ}, 16'd1);
    tick();
    intrDONE = 1; tick(); intrDONE = 0;
    chk("ack_irq", {15'd0, intrREQ}, 16'd0);
    chk("ack_ie",  {15'd0, rhCS1[6]}, 16'd0);

    wr_lo(16'o161);
    errSTAT = 4'b1000; tick();
    chk("tre_set", {15'd0, rhCS1[14]}, 16'd1);
    chk("tre_sc",  {15'd0, rhCS1[15]}, 16'd1);
    tick();
    chk("tre_done", {15'd0, xferBUSY}, 16'd0);
    tick(); tick();
    wr_hi(16'o040000);
    chk("tre_clr", {15'd0, rhCS1[14]}, 16'd0);
    tick(); tick();
    chk("tre_hold", {15'd0, rhCS1[14]}, 16'd0);
    errSTAT = '0;
    intrDONE = 1; tick(); intrDONE = 0;

    wr_lo(16'o61);
    wr_hi(16'o2000);
    chk("psel_busy", {15'd0, rhCS1[10]}, 16'd0);
    xferDONE = 1; tick(); xferDONE = 0; tick();
    wr_hi(16'o2000);
    chk("psel_idle", {15'd0, rhCS1[10]}, 16'd1);
    rhCLR = 1; tick(); rhCLR = 0;
    chk("psel_clr", {15'd0, rhCS1[10]}, 16'd0);

    drvSEL = 1'b1; tick();
    chk("sel1", rhCS1 & 16'o4077, 16'o4065);
    wr_lo(16'o100);
    drvATA = 2'b10; tick();
    chk("ata_irq", {15'd0, intrREQ}, 16'd1);
    chk("ata_sc",  {15'd0, rhCS1[15]}, 16'd1);
    drvATA = '0; intrDONE = 1; tick(); intrDONE = 0;

    wr_lo(16'o161); tick();
    devRESET = 1; xferDONE = 1; tick(); devRESET = 0; xferDONE = 0;
    chk("dr_idle", {15'd0, xferBUSY}, 16'd0);
    chk("dr_irq",  {15'd0, intrREQ}, 16'd0);

    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      devRESET   = ($urandom_range(0, 149) == 0);
      rhCLR      = ($urandom_range(0, 79) == 0);
      rhcs1WRITE = ($urandom_range(0, 3) == 0);
      devLOBYTE  = 1'($urandom);
      devHIBYTE  = 1'($urandom);
      rnd        = {$urandom(), $urandom()};
      devDATAI   = rnd[35:0];
      if ($urandom_range(0, 7) == 0) errSTAT = 4'($urandom);
      if ($urandom_range(0, 7) == 0) drvATA  = 2'($urandom);
      if ($urandom_range(0, 15) == 0) drvCS1 = $urandom();
      drvSEL   = 1'($urandom);
      rhBA     = 2'($urandom);
      xferDONE = ($urandom_range(0, 7) == 0);
      intrDONE = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
`default_nettype wire
